// File: rtl/ap_mult_err_scan.sv
// Exhaustive error scanner for an approximate N x N unsigned multiplier.
// Each cycle it drives one operand pair, compares the returned product with
// the exact product, and accumulates error statistics over the whole space.
module ap_mult_err_scan #(
    parameter int unsigned N       = 4,
    parameter int unsigned DUT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     dut_a,
    output logic [N-1:0]     dut_b,
    input  logic [2*N-1:0]   dut_p,
    output logic [2*N:0]     err_cnt,
    output logic [4*N-1:0]   sum_ed,
    output logic [4*N:0]     sum_err,
    output logic [2*N-1:0]   max_ed,
    output logic [N-1:0]     worst_a,
    output logic [N-1:0]     worst_b
);

    localparam int unsigned W  = 2 * N;
    localparam int unsigned SW = W + 1;
    localparam logic [W-1:0] IdxLast   = '1;
    localparam logic [1:0]   DrainLast = (DUT_LAT == 0) ? 2'd0 : 2'(DUT_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [1:0]     drain_q, drain_d;
    logic [W:0]     err_cnt_q, err_cnt_d;
    logic [2*W-1:0] sum_ed_q, sum_ed_d;
    logic [2*W:0]   sum_err_q, sum_err_d;
    logic [W-1:0]   max_ed_q, max_ed_d;
    logic [N-1:0]   worst_a_q, worst_a_d;
    logic [N-1:0]   worst_b_q, worst_b_d;

    logic           issue;
    logic           clear;
    logic [SW-1:0]  stage_in;
    logic           cmp_vld;
    logic [N-1:0]   cmp_a;
    logic [N-1:0]   cmp_b;
    logic [W-1:0]   exact;
    logic [W:0]     diff;
    logic [W-1:0]   ed;

    assign issue    = (state_q == StRun);
    assign clear    = start && ((state_q == StIdle) || (state_q == StDone));
    // The index register doubles as the registered operand outputs.
    assign stage_in = {issue, idx_q};

    // Tag each issued pair so it meets its product DUT_LAT cycles later
    if (DUT_LAT == 0) begin : g_no_dly
        assign {cmp_vld, cmp_a, cmp_b} = stage_in;
    end else begin : g_dly
        logic [SW-1:0] dly_q [DUT_LAT];

        // Shift register of {valid, a, b}
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DUT_LAT); i++) dly_q[i] <= '0;
            end else begin
                dly_q[0] <= stage_in;
                for (int i = 1; i < int'(DUT_LAT); i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign {cmp_vld, cmp_a, cmp_b} = dly_q[DUT_LAT-1];
    end

    // Next-state and scan-index sequencing
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    idx_d   = '0;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (idx_q == IdxLast) begin
                    // Hold the last pair on the operand outputs.
                    state_d = (DUT_LAT == 0) ? StDone : StDrain;
                    drain_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) state_d = StDone;
                else                      drain_d = drain_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign exact = W'(cmp_a) * W'(cmp_b);
    assign diff  = {1'b0, dut_p} - {1'b0, exact};
    assign ed    = diff[W] ? (exact - dut_p) : (dut_p - exact);

    // Statistic accumulation; an accepted start clears everything
    always_comb begin
        err_cnt_d = err_cnt_q;
        sum_ed_d  = sum_ed_q;
        sum_err_d = sum_err_q;
        max_ed_d  = max_ed_q;
        worst_a_d = worst_a_q;
        worst_b_d = worst_b_q;
        if (clear) begin
            err_cnt_d = '0;
            sum_ed_d  = '0;
            sum_err_d = '0;
            max_ed_d  = '0;
            worst_a_d = '0;
            worst_b_d = '0;
        end else if (cmp_vld) begin
            err_cnt_d = err_cnt_q + {{W{1'b0}}, |ed};
            sum_ed_d  = sum_ed_q + {{W{1'b0}}, ed};
            sum_err_d = sum_err_q + {{W{diff[W]}}, diff};
            // Strict compare keeps the earliest pair on ties.
            if (ed > max_ed_q) begin
                max_ed_d  = ed;
                worst_a_d = cmp_a;
                worst_b_d = cmp_b;
            end
        end
    end

    // State and statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            drain_q   <= '0;
            err_cnt_q <= '0;
            sum_ed_q  <= '0;
            sum_err_q <= '0;
            max_ed_q  <= '0;
            worst_a_q <= '0;
            worst_b_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            err_cnt_q <= err_cnt_d;
            sum_ed_q  <= sum_ed_d;
            sum_err_q <= sum_err_d;
            max_ed_q  <= max_ed_d;
            worst_a_q <= worst_a_d;
            worst_b_q <= worst_b_d;
        end
    end

    assign busy    = (state_q == StRun) || (state_q == StDrain);
    assign done    = (state_q == StDone);
    assign dut_a   = idx_q[W-1:N];
    assign dut_b   = idx_q[N-1:0];
    assign err_cnt = err_cnt_q;
    assign sum_ed  = sum_ed_q;
    assign sum_err = sum_err_q;
    assign max_ed  = max_ed_q;
    assign worst_a = worst_a_q;
    assign worst_b = worst_b_q;

endmodule

// File: tb/tb_ap_mult_err_scan.sv
// Directed bench for ap_mult_err_scan: two scanners (latency 0 and 2) each
// paired with a behavioural multiplier whose fault mode is selectable.
module tb_ap_mult_err_scan;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start0, start2;
    logic       busy0, done0, busy2, done2;
    logic [3:0] a0, b0, a2, b2, wa0, wb0, wa2, wb2;
    logic [7:0] p0, p2, max0, max2;
    logic [8:0] err0, err2;
    logic [15:0] sed0, sed2;
    logic [16:0] serr0, serr2;

    int mode;   // 0 exact, 1 stuck at zero, 2 LSB flipped at (3,5)
    int sel;    // 0 selects the latency-0 scanner, 2 the latency-2 one
    int errors = 0;
    int checks = 0;

    function automatic logic [7:0] mul_model(input logic [3:0] a, input logic [3:0] b,
                                             input int m);
        logic [7:0] p;
        p = {4'b0, a} * {4'b0, b};
        if (m == 1) p = 8'd0;
        else if (m == 2 && a == 4'd3 && b == 4'd5) p = p ^ 8'h01;
        return p;
    endfunction

    assign p0 = mul_model(a0, b0, mode);

    logic [7:0] pipe_s1, pipe_s2;
    always @(posedge clk) begin
        pipe_s1 <= mul_model(a2, b2, mode);
        pipe_s2 <= pipe_s1;
    end
    assign p2 = pipe_s2;

    ap_mult_err_scan #(.N(N), .DUT_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .dut_a(a0), .dut_b(b0), .dut_p(p0), .err_cnt(err0), .sum_ed(sed0),
        .sum_err(serr0), .max_ed(max0), .worst_a(wa0), .worst_b(wb0)
    );

    ap_mult_err_scan #(.N(N), .DUT_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .dut_a(a2), .dut_b(b2), .dut_p(p2), .err_cnt(err2), .sum_ed(sed2),
        .sum_err(serr2), .max_ed(max2), .worst_a(wa2), .worst_b(wb2)
    );

    logic        s_busy, s_done;
    logic [3:0]  s_a, s_b, s_wa, s_wb;
    logic [7:0]  s_max;
    logic [8:0]  s_err;
    logic [15:0] s_sed;
    logic [16:0] s_serr;

    always_comb begin
        if (sel == 2) begin
            s_busy = busy2; s_done = done2; s_a = a2; s_b = b2; s_err = err2;
            s_sed = sed2; s_serr = serr2; s_max = max2; s_wa = wa2; s_wb = wb2;
        end else begin
            s_busy = busy0; s_done = done0; s_a = a0; s_b = b0; s_err = err0;
            s_sed = sed0; s_serr = serr0; s_max = max0; s_wa = wa0; s_wb = wb0;
        end
    end

    typedef struct {
        string name;
        int    lat;
        int    mode;
        int    err;
        int    sed;
        int    serr;
        int    maxed;
        int    wa;
        int    wb;
        int    edges;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 2) start2 = v;
        else          start0 = v;
    endtask

    // Raise start across one rising edge; returns at that edge + 1
    task automatic pulse_start();
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
    endtask

    // Counts edges until done, flagging any cycle where busy drops early
    task automatic wait_done(output int edges, output int busy_bad);
        edges    = 0;
        busy_bad = 0;
        while (!s_done && edges < 1000) begin
            @(posedge clk);
            edges++;
            #1;
            if (!s_done && !s_busy) busy_bad++;
        end
    endtask

    task automatic check_stats(input string tag, input vec_t v);
        chk({tag, " err_cnt"}, s_err, v.err);
        chk({tag, " sum_ed"}, s_sed, v.sed);
        chk({tag, " sum_err"}, longint'($signed(s_serr)), v.serr);
        chk({tag, " max_ed"}, s_max, v.maxed);
        chk({tag, " worst_a"}, s_wa, v.wa);
        chk({tag, " worst_b"}, s_wb, v.wb);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"}, s_busy, 0);
        chk({tag, " done"}, s_done, 0);
        chk({tag, " operands"}, {s_a, s_b}, 0);
        chk({tag, " stats"}, {s_err, s_sed, s_serr, s_max, s_wa, s_wb}, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int edges, busy_bad;
        sel  = v.lat;
        mode = v.mode;
        pulse_start();
        chk({v.name, " busy after accept"}, s_busy, 1);
        wait_done(edges, busy_bad);
        chk({v.name, " edges to done"}, edges, v.edges);
        chk({v.name, " busy drops early"}, busy_bad, 0);
        chk({v.name, " busy in done"}, s_busy, 0);
        chk({v.name, " last pair"}, {s_a, s_b}, 8'hff);
        check_stats(v.name, v);
        @(posedge clk);
        #1;
        chk({v.name, " done one cycle"}, s_done, 0);
        check_stats({v.name, " held"}, v);
    endtask

    initial begin
        int edges, busy_bad, done_seen;

        vecs[0] = '{"exact_l0", 0, 0, 0, 0, 0, 0, 0, 0, 256};
        vecs[1] = '{"zero_l0", 0, 1, 225, 14400, -14400, 225, 15, 15, 256};
        vecs[2] = '{"flip35_l0", 0, 2, 1, 1, -1, 1, 3, 5, 256};
        vecs[3] = '{"exact_l2", 2, 0, 0, 0, 0, 0, 0, 0, 258};
        vecs[4] = '{"zero_l2", 2, 1, 225, 14400, -14400, 225, 15, 15, 258};

        rst_n  = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        mode   = 0;
        sel    = 0;
        #1;
        check_zero("reset l0");
        sel = 2;
        #1;
        check_zero("reset l2");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // A start pulse mid-scan must not restart the scan
        sel  = 0;
        mode = 2;
        pulse_start();
        repeat (49) @(posedge clk);
        pulse_start();
        wait_done(edges, busy_bad);
        chk("overlap edges to done", edges + 50, 256);
        chk("overlap busy drops early", busy_bad, 0);
        check_stats("overlap", vecs[2]);

        // Reset mid-scan aborts at once and never yields done
        mode = 1;
        pulse_start();
        repeat (100) @(posedge clk);
        #1;
        chk("pre-abort busy", s_busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        done_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (s_done) done_seen++;
        end
        chk("abort no done", done_seen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[1]);

        // Start held in DONE launches the next scan with cleared statistics
        sel  = 0;
        mode = 1;
        pulse_start();
        wait_done(edges, busy_bad);
        chk("b2b first edges", edges, 256);
        check_stats("b2b first", vecs[1]);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        chk("b2b restart busy", s_busy, 1);
        chk("b2b cleared", {s_err, s_sed, s_serr, s_max, s_wa, s_wb}, 0);
        chk("b2b operands", {s_a, s_b}, 0);
        wait_done(edges, busy_bad);
        chk("b2b second edges", edges, 256);
        chk("b2b busy drops early", busy_bad, 0);
        check_stats("b2b second", vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ap_mult_err_scan.md
# ap_mult_err_scan

Exhaustive error-characterization engine for the approximate unsigned multipliers built from approximate compressors. On `start`, it drives every operand pair (a, b) in the N-bit × N-bit space into a multiplier under test, one pair per cycle, and reads back the product. It compares each product against the exact product and accumulates error metrics. It sits beside a candidate multiplier in the evaluation harness and is the consumer/checker of that multiplier's output.

## Interface
Parameters:
- `N`, default 4: operand width. Legal range 2..8.
- `DUT_LAT`, default 0: pipeline latency of the multiplier under test in cycles. Legal range 0..3. 0 means purely combinational.

Ports:
- `clk` input 1: the single clock. All state is updated on its rising edge.
- `rst_n` input 1: reset. Asynchronous, active-low.
- `start` input 1: begin a scan. Sampled only in IDLE or DONE.
- `busy` output 1: high while a scan is in progress.
- `done` output 1: one-cycle pulse when the statistics are final.
- `dut_a` output N: operand a driven to the multiplier. Registered.
- `dut_b` output N: operand b driven to the multiplier. Registered.
- `dut_p` input 2N: product returned by the multiplier.
- `err_cnt` output 2N+1: number of pairs where `dut_p` ≠ a·b.
- `sum_ed` output 4N: sum of |dut_p − a·b| over all pairs.
- `sum_err` output 4N+1: signed sum of (dut_p − a·b), two's complement.
- `max_ed` output 2N: maximum |dut_p − a·b|.
- `worst_a` output N: operand a of the earliest pair that attains `max_ed`.
- `worst_b` output N: operand b of the earliest pair that attains `max_ed`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE or DONE with `start`=1 → RUN. On the same edge, all statistics clear to 0, the 2N-bit index `idx` clears to 0, and `dut_a`/`dut_b` become 0/0.
  - RUN: each cycle presents pair `idx` on the operand outputs, with `dut_a`=idx[2N-1:N] and `dut_b`=idx[N-1:0]. `idx` increments every cycle.
  - RUN → DRAIN after presenting idx = 2^(2N)−1, when `DUT_LAT`>0. RUN → DONE directly when `DUT_LAT`=0.
  - DRAIN: lasts `DUT_LAT` cycles, then → DONE.
  - DONE: `done`=1 for exactly one cycle, then → IDLE unless `start`=1.
- An internal valid/operand delay line of depth `DUT_LAT` tags each issued pair. The pair issued in cycle t is compared against `dut_p` in cycle t+`DUT_LAT`.
- Exact product: computed internally as a·b, 2N bits, from the delayed operands.
- Per compared pair:
  - ed = |dut_p − exact|, 2N bits, never overflows.
  - `err_cnt` += (ed≠0).
  - `sum_ed` += ed.
  - `sum_err` += dut_p − exact, sign-extended.
  - If ed > `max_ed`, update `max_ed`, `worst_a`, `worst_b`. Use strict greater-than, so on ties the earliest index is kept.
- Statistics hold their values after DONE until the next accepted `start`.
- `start` while `busy`=1 is ignored. The scan is not restarted.
- After the scan, `dut_a`/`dut_b` hold the last pair presented.

## Timing
- Reset (asynchronous, `rst_n`=0): state=IDLE, `busy`=0, `done`=0, `dut_a`=`dut_b`=0, and all statistics 0. Reset asserted mid-scan aborts immediately. No partial `done` is produced.
- `busy`=1 from the cycle after `start` is accepted through the last DRAIN cycle. `busy`=0 in DONE and IDLE.
- Accumulation of pair k happens on the edge ending cycle k+1+`DUT_LAT`, counting cycle 1 as the first RUN cycle.
- `done` is high in cycle 2^(2N)+`DUT_LAT`+1 after the accepting edge, i.e. 2^(2N)+`DUT_LAT` edges after that edge. For N=4, `DUT_LAT`=0, this is 256 edges later.
- The statistics outputs are valid and stable in the `done` cycle.
- Throughput: one pair per cycle, with no bubbles between pairs.

## Test plan
- Exact DUT (dut_p = a·b combinational), N=4, `DUT_LAT`=0 → `err_cnt`=0, `sum_ed`=0, `sum_err`=0, `max_ed`=0, worst=(0,0). `done` arrives 256 edges after start.
- DUT stuck at 0, N=4 → `err_cnt`=225, `sum_ed`=14400, `sum_err`=−14400, `max_ed`=225, `worst_a`=15, `worst_b`=15.
- DUT exact except the LSB is flipped for (3,5) only (outputs 14) → `err_cnt`=1, `sum_ed`=1, `sum_err`=−1, `max_ed`=1, worst=(3,5).
- `DUT_LAT`=2, exact DUT with a two-stage register pipeline → zero errors. `done` arrives 258 edges after start. `busy` stays high through the 2 DRAIN cycles.
- Abort and overlap: `start` pulsed at cycle 50 of a scan → ignored, and the scan completes with correct totals. Separately, `rst_n` driven low at cycle 100 → all outputs 0 immediately and no `done`. A new `start` after reset gives the full correct result.
- Back-to-back scans: `start` held high during DONE → the new scan begins and its statistics clear on the accepting edge. Results match the first run.
